// File: rtl/br_flow_mux_wrr_stable.sv
// -----------------------------------------------------------------------------
// br_flow_mux_wrr_stable
//
// Weighted round-robin flow mux with a registered pop side. NumFlows push
// flows share one pop interface. The flow that starts a burst may keep the
// grant for up to max(config_weight[flow],1) consecutive transfers. After
// that, the grant rotates to the next valid flow in cyclic order.
//
// Handshake rule (push and pop): a beat moves on a rising clk edge where
// valid && ready are both high. pop_valid/pop_data come from a register and
// hold steady while pop_valid && !pop_ready. push_ready may change from
// cycle to cycle. It is never high for a flow that is not the current
// grant.
//
// Ports:
//   clk            clock
//   rst            synchronous, active-high reset
//   config_weight  per-flow burst length, NumFlows x WeightWidth; 0 counts as 1
//   push_ready     per-flow ready, one-hot or zero
//   push_valid     per-flow valid
//   push_data      per-flow data, NumFlows x Width
//   pop_ready      downstream ready
//   pop_valid      registered valid
//   pop_data       registered data
//
// Legal parameters: NumFlows >= 2, Width >= 1, MaxWeight >= 1.
// WeightWidth is derived from MaxWeight. Do not override it.
// -----------------------------------------------------------------------------
module br_flow_mux_wrr_stable #(
  parameter int NumFlows    = 2,
  parameter int Width       = 1,
  parameter int MaxWeight   = 4,
  parameter int WeightWidth = $clog2(MaxWeight + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NumFlows*WeightWidth-1:0] config_weight,
  output logic [NumFlows-1:0]             push_ready,
  input  logic [NumFlows-1:0]             push_valid,
  input  logic [NumFlows*Width-1:0]       push_data,
  input  logic                            pop_ready,
  output logic                            pop_valid,
  output logic [Width-1:0]                pop_data
);

  localparam int IdxWidth = $clog2(NumFlows);
  localparam logic [IdxWidth-1:0]    LastFlow  = IdxWidth'(NumFlows - 1);
  localparam logic [WeightWidth-1:0] WeightOne = WeightWidth'(1);
  localparam logic [WeightWidth-1:0] WeightMax = WeightWidth'(MaxWeight);

  // Arbitration state. sticky means "owner still has burst credit";
  // burst_cnt counts the remaining credit after the current beat.
  logic [IdxWidth-1:0]    owner;
  logic                   sticky;
  logic [WeightWidth-1:0] burst_cnt;

  logic                   can_accept;
  logic                   owner_valid;
  logic                   grant_valid;
  logic [IdxWidth-1:0]    grant;
  logic [Width-1:0]       grant_data;
  logic [WeightWidth-1:0] grant_weight;
  logic [WeightWidth-1:0] reload_cnt;
  logic                   start_burst;
  logic                   push_xfer;

  logic [2*NumFlows-1:0]  valid_doubled;
  logic [NumFlows-1:0]    valid_rot;
  logic [IdxWidth:0]      rot_amt;
  int                     scan_idx;

  assign can_accept = !pop_valid || pop_ready;

  // Rotate push_valid so bit j is the flow at owner+1+j (mod NumFlows).
  // The lowest set bit is then the round-robin winner. The owner lands in
  // the top bit, so it is checked last.
  always_comb begin
    valid_doubled = {push_valid, push_valid};
    rot_amt       = {1'b0, owner} + (IdxWidth + 1)'(1);
    valid_rot     = NumFlows'(valid_doubled >> rot_amt);
  end

  always_comb begin
    owner_valid = 1'b0;
    for (int i = 0; i < NumFlows; i++) begin
      if (IdxWidth'(i) == owner) owner_valid = push_valid[i];
    end
  end

  // Grant selection. A burst in progress keeps the grant only while the
  // owner is valid. Otherwise the grant falls through to round-robin from
  // owner+1 in the same cycle, so dropping valid costs no bubble.
  always_comb begin
    grant_valid = 1'b0;
    grant       = owner;
    scan_idx    = 0;
    if (sticky && owner_valid) begin
      grant_valid = 1'b1;
    end else begin
      for (int j = NumFlows - 1; j >= 0; j--) begin
        if (valid_rot[j]) begin
          grant_valid = 1'b1;
          scan_idx    = int'(owner) + 1 + j;
        end
      end
      if (scan_idx >= NumFlows) scan_idx = scan_idx - NumFlows;
      if (grant_valid) grant = IdxWidth'(scan_idx);
    end
  end

  always_comb begin
    grant_data   = '0;
    grant_weight = '0;
    for (int i = 0; i < NumFlows; i++) begin
      if (IdxWidth'(i) == grant) begin
        grant_data   = push_data[i*Width +: Width];
        grant_weight = config_weight[i*WeightWidth +: WeightWidth];
      end
    end
  end

  always_comb begin
    push_ready = '0;
    for (int i = 0; i < NumFlows; i++) begin
      push_ready[i] = can_accept && grant_valid && !rst && (IdxWidth'(i) == grant);
    end
  end

  assign push_xfer   = can_accept && grant_valid && !rst;
  assign start_burst = (grant != owner) || !sticky;
  // Weight 0 behaves as 1, so the reload value (weight-1) is 0 in both cases.
  assign reload_cnt  = (grant_weight == '0) ? '0 : grant_weight - WeightOne;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= LastFlow;
      sticky    <= 1'b0;
      burst_cnt <= '0;
      pop_valid <= 1'b0;
      pop_data  <= '0;
    end else begin
      if (push_xfer) begin
        pop_valid <= 1'b1;
        pop_data  <= grant_data;
        if (start_burst) begin
          owner     <= grant;
          burst_cnt <= reload_cnt;
          sticky    <= (reload_cnt != '0);
        end else begin
          burst_cnt <= burst_cnt - WeightOne;
          sticky    <= (burst_cnt != WeightOne);
        end
      end else begin
        if (pop_ready) pop_valid <= 1'b0;
        // Owner went idle while the output could take a beat: the burst
        // is forfeited. Under backpressure the credit is kept.
        if (can_accept && sticky && !owner_valid) sticky <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  a_push_ready_onehot0 : assert property (@(posedge clk) disable iff (rst)
    $onehot0(push_ready));
  a_pop_data_stable : assert property (@(posedge clk) disable iff (rst)
    (pop_valid && !pop_ready) |=> $stable(pop_data));
  a_burst_cnt_range : assert property (@(posedge clk) disable iff (rst)
    burst_cnt < WeightMax || MaxWeight == 0);
  a_no_xfer_when_full : assert property (@(posedge clk) disable iff (rst)
    !can_accept |-> ((push_ready & push_valid) == '0));
  for (genvar gi = 0; gi < NumFlows; gi++) begin : g_weight_chk
    a_weight_legal : assert property (@(posedge clk) disable iff (rst)
      config_weight[gi*WeightWidth +: WeightWidth] <= WeightMax);
  end
`endif

endmodule

// File: tb/tb_br_flow_mux_wrr_stable.sv
// -----------------------------------------------------------------------------
// tb_br_flow_mux_wrr_stable
//
// Bench for br_flow_mux_wrr_stable with 4 flows and 8-bit data. The reference
// model tracks the current owner, the beats left in its burst and the single
// pop slot, held as a queue of pending beats.
// -----------------------------------------------------------------------------
module tb_br_flow_mux_wrr_stable;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXW = 4;
  localparam int WW   = $clog2(MAXW + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*WW-1:0] config_weight;
  logic [N-1:0]    push_ready;
  logic [N-1:0]    push_valid;
  logic [N*W-1:0]  push_data;
  logic            pop_ready = 1'b0;
  logic            pop_valid;
  logic [W-1:0]    pop_data;

  // Driver-side state.
  bit       vld[N];
  logic [W-1:0] data_arr[N];
  int       wts[N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      push_valid[i]            = vld[i];
      push_data[i*W +: W]      = data_arr[i];
      config_weight[i*WW +: WW] = WW'(wts[i]);
    end
  end

  br_flow_mux_wrr_stable #(
    .NumFlows (N),
    .Width    (W),
    .MaxWeight(MAXW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .config_weight(config_weight),
    .push_ready   (push_ready),
    .push_valid   (push_valid),
    .push_data    (push_data),
    .pop_ready    (pop_ready),
    .pop_valid    (pop_valid),
    .pop_data     (pop_data)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  int m_owner   = N - 1;
  int m_credits = 0;
  int m_beats[N];
  int dut_beats[N];
  int wait_beats[N];
  int grant_log[$];
  bit stress = 0;
  logic [N-1:0] xfer_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int eff_w(input int f);
    return (wts[f] == 0) ? 1 : wts[f];
  endfunction

  // Winner under the WRR rules: the owner keeps the grant while it has
  // credit and is valid. Otherwise the grant goes to the first valid flow
  // after the owner, in cyclic order.
  function automatic int model_pick();
    if (m_credits > 0 && vld[m_owner]) return m_owner;
    for (int k = 1; k <= N; k++) begin
      if (vld[(m_owner + k) % N]) return (m_owner + k) % N;
    end
    return -1;
  endfunction

  // Called at the falling edge. Inputs are stable until the next rising
  // edge, so the model can be advanced here.
  task automatic sample();
    logic [N-1:0] exp_rdy;
    bit can_acc;
    int g;
    bit m_xfer;
    can_acc = (exp_q.size() == 0) || pop_ready;
    g       = model_pick();
    exp_rdy = '0;
    m_xfer  = 0;
    if (!rst && can_acc && g >= 0) begin
      exp_rdy[g] = 1'b1;
      m_xfer     = 1;
    end
    check("push_ready", 32'(push_ready), 32'(exp_rdy));
    check("pop_valid", 32'(pop_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("pop_data", 32'(pop_data), 32'(exp_q[0]));

    xfer_seen = push_ready & push_valid;
    for (int i = 0; i < N; i++) begin
      if (xfer_seen[i]) begin
        grant_log.push_back(i);
        dut_beats[i]++;
      end
      if (stress) begin
        if (xfer_seen[i]) begin
          check("fair_wait", 32'(wait_beats[i] <= 10), 32'd1);
          wait_beats[i] = 0;
        end else if (vld[i]) begin
          if (xfer_seen != '0) wait_beats[i]++;
        end else begin
          wait_beats[i] = 0;
        end
      end
    end

    if (rst) begin
      exp_q.delete();
      m_owner   = N - 1;
      m_credits = 0;
    end else begin
      if (pop_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (m_xfer) begin
        exp_q.push_back(data_arr[g]);
        m_beats[g]++;
        if (g == m_owner && m_credits > 0) m_credits--;
        else begin
          m_owner   = g;
          m_credits = eff_w(g) - 1;
        end
      end else if (can_acc && m_credits > 0) begin
        m_credits = 0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    check("rst_pop_valid", 32'(pop_valid), 32'd0);
    check("rst_pop_data", 32'(pop_data), 32'd0);
    check("rst_push_ready", 32'(push_ready), 32'd0);
    grant_log.delete();
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) data_arr[i] = W'($urandom);
  endtask

  task automatic check_log(input string tag, input int e[$]);
    check({tag, "_len"}, 32'(grant_log.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < grant_log.size(); i++)
      check($sformatf("%s_%0d", tag, i), 32'(grant_log[i]), 32'(e[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_seq[$];
    int cyc;
    logic [W-1:0] first_beat;

    for (int i = 0; i < N; i++) begin
      vld[i] = 0; data_arr[i] = '0; wts[i] = 1;
      m_beats[i] = 0; dut_beats[i] = 0; wait_beats[i] = 0;
    end
    @(posedge clk);
    #1;

    // All three flows valid, weights {2,1,3}.
    wts[0] = 2; wts[1] = 1; wts[2] = 3; wts[3] = 1;
    do_reset();
    vld[0] = 1; vld[1] = 1; vld[2] = 1; vld[3] = 0;
    pop_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      rand_data();
      cycle();
      if (c > 0) check("full_rate_valid", 32'(pop_valid), 32'd1);
    end
    exp_seq = {0, 0, 1, 2, 2, 2, 0, 0, 1, 2, 2, 2};
    check_log("wrr_order", exp_seq);

    // Backpressure in the middle of flow 0's burst.
    do_reset();
    pop_ready = 1'b1;
    rand_data();
    first_beat = data_arr[0];
    cycle();
    for (int c = 0; c < 4; c++) begin
      pop_ready = 1'b0;
      rand_data();
      #1;
      check("stall_push_ready", 32'(push_ready), 32'd0);
      cycle();
      check("stall_pop_data", 32'(pop_data), 32'(first_beat));
    end
    pop_ready = 1'b1;
    cyc = 0;
    while (grant_log.size() < 6 && cyc < 30) begin
      rand_data();
      cycle();
      cyc++;
    end
    exp_seq = {0, 0, 1, 2, 2, 2};
    check_log("stall_order", exp_seq);

    // Flow 2 drops valid after one beat of its weight-3 burst.
    do_reset();
    cyc = 0;
    while (grant_log.size() < 7 && cyc < 30) begin
      vld[2] = (grant_log.size() < 4);
      rand_data();
      cycle();
      cyc++;
    end
    check("drop_cycles", 32'(cyc), 32'd7);
    exp_seq = {0, 0, 1, 2, 0, 0, 1};
    check_log("drop_order", exp_seq);

    // Only flow 1 valid, with weight 0.
    wts[1] = 0;
    do_reset();
    vld[0] = 0; vld[1] = 1; vld[2] = 0; vld[3] = 0;
    for (int c = 0; c < 6; c++) begin
      rand_data();
      #1;
      check("solo_push_ready", 32'(push_ready), 32'b0010);
      cycle();
    end
    exp_seq = {1, 1, 1, 1, 1, 1};
    check_log("solo_order", exp_seq);

    // Reset while a beat is held and a burst is in progress.
    wts[1] = 1;
    do_reset();
    vld[0] = 1; vld[1] = 1; vld[2] = 1; vld[3] = 0;
    pop_ready = 1'b0;
    rand_data();
    cycle();
    check("pre_rst_pop_valid", 32'(pop_valid), 32'd1);
    rst = 1'b1;
    cycle();
    check("mid_rst_pop_valid", 32'(pop_valid), 32'd0);
    check("mid_rst_pop_data", 32'(pop_data), 32'd0);
    rst = 1'b0;
    pop_ready = 1'b1;
    grant_log.delete();
    rand_data();
    cycle();
    exp_seq = {0};
    check_log("post_rst_first", exp_seq);

    // Random valid/ready stress with weights {1,4,2,3}.
    wts[0] = 1; wts[1] = 4; wts[2] = 2; wts[3] = 3;
    do_reset();
    for (int i = 0; i < N; i++) begin
      m_beats[i] = 0; dut_beats[i] = 0; wait_beats[i] = 0; vld[i] = 0;
    end
    xfer_seen = '0;
    stress = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!vld[i] || xfer_seen[i]) begin
          vld[i]      = ($urandom_range(0, 3) != 0);
          data_arr[i] = W'($urandom);
        end
      end
      pop_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    stress = 0;
    for (int i = 0; i < N; i++)
      check($sformatf("beats_flow%0d", i), 32'(dut_beats[i]), 32'(m_beats[i]));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
